qbus_dma_arb: RTL and testbench
===============================

QBUS_DMA_ARB -- requirements
Module: qbus_dma_arb

Interface
REQ-001 Parameter NDEV, default 4, SHALL set the number of DMA requesters (2..8).
REQ-002 Parameter TMO, default 640, SHALL set the grant-to-SACK timeout in pin_clk cycles (≥ 2).
REQ-003 pin_clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 pin_rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 dev_dmr_n  in  NDEV  SHALL carry per-device DMA requests, active-low, already synchronous to pin_clk.
REQ-006 dev_sack_n  in  NDEV  SHALL carry per-device bus acknowledge, active-low.
REQ-007 dev_dmg_n  out  NDEV  SHALL carry per-device DMA grant, active-low, at most one bit low.
REQ-008 pin_dmr_n  out  1  SHALL carry the bus request to the CPU, active-low.
REQ-009 pin_dmgo_n  in  1  SHALL carry the CPU bus-grant output, active-low.
REQ-010 pin_sack_n  out  1  SHALL carry the bus acknowledge to the CPU, active-low.
REQ-011 bus_own  out  NDEV  SHALL flag the current bus master, one-hot, active-high.
REQ-012 tmo_err  out  1  SHALL be a one-cycle active-high grant-timeout pulse.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 States: IDLE, REQ, GRANT, OWN.
REQ-015 IDLE: any dev_dmr_n low SHALL select winner W = first low request at or after round-robin pointer RR (wrapping NDEV-1→0), latch W, go to REQ, and drive pin_dmr_n low the next cycle.
REQ-016 In IDLE with no requests, all outputs SHALL stay inactive.
REQ-017 REQ: pin_dmgo_n low SHALL go to GRANT, drive dev_dmg_n[W] low the next cycle, and clear the timer.
REQ-018 REQ: dev_dmr_n[W] high before the grant SHALL return to IDLE and negate pin_dmr_n; RR SHALL be unchanged.
REQ-019 GRANT: dev_sack_n[W] low SHALL go to OWN.
REQ-020 On entry to OWN: pin_sack_n low, bus_own[W]=1, dev_dmg_n all high, pin_dmr_n high.
REQ-021 GRANT: the timer SHALL increment every cycle.
REQ-022 GRANT: timer reaching TMO-1 without SACK SHALL drop the grant, pulse tmo_err, set RR=W+1 mod NDEV, and go to IDLE.
REQ-023 GRANT: dev_dmr_n[W] high without SACK SHALL drop the grant, go to IDLE, and set RR=W+1 without tmo_err.
REQ-024 OWN: dev_sack_n[W] high SHALL negate pin_sack_n and bus_own, set RR=W+1 mod NDEV, and go to IDLE.
REQ-025 After leaving OWN, IDLE SHALL last one cycle before the next arbitration.
REQ-026 Requests from other devices during REQ/GRANT/OWN SHALL be held pending and never preempt W.
REQ-027 SACK from any device other than W SHALL be ignored.
REQ-028 Simultaneous events in GRANT SHALL resolve in this priority: SACK, then timeout, then request withdrawal.
REQ-029 The timer SHALL be ceil(log2(TMO)) bits and SHALL saturate, never wrap.

Reset
REQ-030 pin_rst high SHALL force IDLE on the next clock edge, including mid-GRANT or mid-OWN.
REQ-031 Reset values: RR=0, timer=0, dev_dmg_n all 1, pin_dmr_n=1, pin_sack_n=1, bus_own=0, tmo_err=0.

Structure
REQ-032 Shared package qbus_pkg SHALL hold the state enumeration and default NDEV/TMO constants.
REQ-033 Round-robin selection SHALL be a sub-module qbus_rr_pick (inputs: request vector, pointer; outputs: one-hot winner, valid), purely combinational.

Verification
REQ-034 Single request: dev_dmr_n=4'b1110, pin_dmgo_n low 3 cycles after pin_dmr_n falls, device 0 SACKs after 2 cycles, holds 10 cycles -> dev_dmg_n[0] low 1 cycle after dmgo, pin_sack_n low 10 cycles, RR=1 at end.
REQ-035 Fairness: all four requests held low continuously, each bus tenure completed -> grant order 0,1,2,3,0.
REQ-036 Timeout: device 2 granted but never SACKs -> grant dropped and tmo_err high exactly 1 cycle, TMO cycles after grant; next winner is device 3.
REQ-037 Withdrawal: device 1 releases dev_dmr_n in REQ before dmgo -> pin_dmr_n high next cycle, no grant, RR unchanged.
REQ-038 Reset in OWN: pin_rst pulsed 1 cycle while device 0 owns the bus -> all outputs at reset values next cycle, RR=0.
REQ-039 Stray SACK: device 3 asserts SACK while device 1 is in GRANT -> no state change and pin_sack_n stays high.

Source files
------------

// File: rtl/qbus_pkg.sv
// qbus_pkg: shared arbiter state encoding, default sizing and index helper.
package qbus_pkg;
  typedef enum logic [1:0] {IDLE, REQ, GRANT, OWN} state_e;
  localparam int NDEV_DEF = 4;
  localparam int TMO_DEF = 640;
  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    oh2idx = '0;
    for (int i = 0; i < 8; i++) if (oh[i]) oh2idx = 3'(i);
  endfunction
endpackage

// File: rtl/qbus_dma_arb_if.sv
// qbus_dma_arb_if: Q-bus DMA request/grant/acknowledge signal bundle.
interface qbus_dma_arb_if #(parameter int NDEV = qbus_pkg::NDEV_DEF);
  logic [NDEV-1:0] dev_dmr_n;
  logic [NDEV-1:0] dev_sack_n;
  logic [NDEV-1:0] dev_dmg_n;
  logic [NDEV-1:0] bus_own;
  logic pin_dmr_n;
  logic pin_dmgo_n;
  logic pin_sack_n;
  logic tmo_err;
  modport master(input dev_dmr_n, dev_sack_n, pin_dmgo_n, output dev_dmg_n, bus_own, pin_dmr_n, pin_sack_n, tmo_err);
  modport slave(output dev_dmr_n, dev_sack_n, pin_dmgo_n, input dev_dmg_n, bus_own, pin_dmr_n, pin_sack_n, tmo_err);
endinterface

// File: rtl/qbus_rr_pick.sv
// qbus_rr_pick: combinational round-robin pick of the first request at or after ptr_i.
module qbus_rr_pick import qbus_pkg::*; #(
  parameter int NDEV = NDEV_DEF
) (
  input  logic [NDEV-1:0]         req_i,
  input  logic [$clog2(NDEV)-1:0] ptr_i,
  output logic [NDEV-1:0]         win_o,
  output logic                    valid_o
);
  localparam int IW = $clog2(NDEV);
  assign valid_o = |req_i;
  always_comb begin
    win_o = '0;
    // scan farthest offset first so the nearest request overwrites
    for (int i = NDEV - 1; i >= 0; i--)
      if (req_i[IW'((int'(ptr_i) + i) % NDEV)]) win_o = NDEV'(1) << ((int'(ptr_i) + i) % NDEV);
  end
endmodule

// File: rtl/qbus_dma_arb.sv
// qbus_dma_arb: round-robin Q-bus DMA arbiter with grant timeout, all outputs registered.
module qbus_dma_arb import qbus_pkg::*; #(
  parameter int NDEV = NDEV_DEF,
  parameter int TMO  = TMO_DEF
) (
  input logic             pin_clk,
  input logic             pin_rst,
  qbus_dma_arb_if.master  bus
);
  localparam int IW = $clog2(NDEV);
  localparam int TW = $clog2(TMO);
  localparam logic [TW-1:0] TLAST = TW'(TMO - 1);
  localparam logic [IW-1:0] WLAST = IW'(NDEV - 1);
  state_e state_q, state_d;
  logic [IW-1:0] w_q, w_d, rr_q, rr_d, w_inc;
  logic [TW-1:0] timer_q, timer_d;
  logic [NDEV-1:0] win, dmg_n_q, dmg_n_d, own_q, own_d;
  logic valid, dmr_n_q, dmr_n_d, sack_n_q, sack_n_d, tmo_q, tmo_d;
  qbus_rr_pick #(.NDEV(NDEV)) u_pick (
    .req_i  (~bus.dev_dmr_n),
    .ptr_i  (rr_q),
    .win_o  (win),
    .valid_o(valid)
  );
  assign w_inc = (w_q == WLAST) ? '0 : w_q + 1'b1;
  always_comb begin
    state_d = state_q;
    w_d = w_q;
    rr_d = rr_q;
    timer_d = timer_q;
    tmo_d = 1'b0;
    case (state_q)
      IDLE: if (valid) begin
        state_d = REQ;
        w_d = IW'(oh2idx(8'(win)));
      end
      REQ: if (!bus.pin_dmgo_n) begin
        state_d = GRANT;
        timer_d = '0;
      end else if (bus.dev_dmr_n[w_q]) state_d = IDLE;
      GRANT: begin
        timer_d = (timer_q == TLAST) ? timer_q : timer_q + 1'b1;
        if (!bus.dev_sack_n[w_q]) state_d = OWN;
        else if (timer_q == TLAST) begin
          state_d = IDLE;
          tmo_d = 1'b1;
          rr_d = w_inc;
        end else if (bus.dev_dmr_n[w_q]) begin
          state_d = IDLE;
          rr_d = w_inc;
        end
      end
      OWN: if (bus.dev_sack_n[w_q]) begin
        state_d = IDLE;
        rr_d = w_inc;
      end
    endcase
    // outputs are a pure function of the next state so they register cleanly
    dmr_n_d = !(state_d == REQ || state_d == GRANT);
    dmg_n_d = (state_d == GRANT) ? ~(NDEV'(1) << w_d) : '1;
    own_d = (state_d == OWN) ? NDEV'(1) << w_d : '0;
    sack_n_d = state_d != OWN;
  end
  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      state_q <= IDLE;
      w_q <= '0;
      rr_q <= '0;
      timer_q <= '0;
      dmg_n_q <= '1;
      own_q <= '0;
      dmr_n_q <= 1'b1;
      sack_n_q <= 1'b1;
      tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q <= w_d;
      rr_q <= rr_d;
      timer_q <= timer_d;
      dmg_n_q <= dmg_n_d;
      own_q <= own_d;
      dmr_n_q <= dmr_n_d;
      sack_n_q <= sack_n_d;
      tmo_q <= tmo_d;
    end
  end
  assign bus.dev_dmg_n = dmg_n_q;
  assign bus.bus_own = own_q;
  assign bus.pin_dmr_n = dmr_n_q;
  assign bus.pin_sack_n = sack_n_q;
  assign bus.tmo_err = tmo_q;
endmodule

// File: tb/tb_qbus_dma_arb.sv
// tb_qbus_dma_arb: directed scenarios plus random traffic against a cycle-stamped behavioural model.
module tb_qbus_dma_arb;
  localparam int NDEV = 4;
  localparam int TMO = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NDEV-1:0] dmr_n = '1;
  logic [NDEV-1:0] sack_n = '1;
  logic dmgo_n = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int m_ph = 0;
  int m_w = 0;
  int m_rr = 0;
  int m_gs = 0;
  qbus_dma_arb_if #(.NDEV(NDEV)) bus_if ();
  assign bus_if.dev_dmr_n = dmr_n;
  assign bus_if.dev_sack_n = sack_n;
  assign bus_if.pin_dmgo_n = dmgo_n;
  qbus_dma_arb #(.NDEV(NDEV), .TMO(TMO)) dut (
    .pin_clk(clk),
    .pin_rst(rst),
    .bus    (bus_if)
  );
  always #5 clk = ~clk;
  function automatic logic bit_at(input logic [NDEV-1:0] v, input int i);
    logic [NDEV-1:0] t;
    t = v >> i;
    return t[0];
  endfunction
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask
  // phases: 0 idle, 1 bus requested, 2 device granted, 3 device owns bus
  task automatic step();
    int ph, w, rr, gs;
    logic tp;
    int cand[$];
    logic [NDEV-1:0] e_dmg, e_own;
    ph = m_ph;
    w = m_w;
    rr = m_rr;
    gs = m_gs;
    tp = 1'b0;
    if (rst) begin
      ph = 0;
      w = 0;
      rr = 0;
    end else if (m_ph == 0) begin
      for (int i = 0; i < NDEV; i++) if (!bit_at(dmr_n, (m_rr + i) % NDEV)) cand.push_back((m_rr + i) % NDEV);
      if (cand.size() > 0) begin
        ph = 1;
        w = cand[0];
      end
    end else if (m_ph == 1) begin
      if (!dmgo_n) begin
        ph = 2;
        gs = cyc + 1;
      end else if (bit_at(dmr_n, m_w)) ph = 0;
    end else if (m_ph == 2) begin
      if (!bit_at(sack_n, m_w)) ph = 3;
      else if (cyc - m_gs + 1 >= TMO) begin
        ph = 0;
        tp = 1'b1;
        rr = (m_w + 1) % NDEV;
      end else if (bit_at(dmr_n, m_w)) begin
        ph = 0;
        rr = (m_w + 1) % NDEV;
      end
    end else if (bit_at(sack_n, m_w)) begin
      ph = 0;
      rr = (m_w + 1) % NDEV;
    end
    @(posedge clk);
    cyc++;
    m_ph = ph;
    m_w = w;
    m_rr = rr;
    m_gs = gs;
    #1;
    e_dmg = (ph == 2) ? ~(NDEV'(1) << w) : '1;
    e_own = (ph == 3) ? NDEV'(1) << w : '0;
    cmp("pin_dmr_n", 32'(bus_if.pin_dmr_n), 32'(!(ph == 1 || ph == 2)));
    cmp("dev_dmg_n", 32'(bus_if.dev_dmg_n), 32'(e_dmg));
    cmp("pin_sack_n", 32'(bus_if.pin_sack_n), 32'(ph != 3));
    cmp("bus_own", 32'(bus_if.bus_own), 32'(e_own));
    cmp("tmo_err", 32'(bus_if.tmo_err), 32'(tp));
  endtask
  task automatic chk_reset_outputs(input string nm);
    cmp({nm, "_dmg_n"}, 32'(bus_if.dev_dmg_n), 32'hF);
    cmp({nm, "_dmr_n"}, 32'(bus_if.pin_dmr_n), 32'd1);
    cmp({nm, "_sack_n"}, 32'(bus_if.pin_sack_n), 32'd1);
    cmp({nm, "_own"}, 32'(bus_if.bus_own), 32'd0);
    cmp({nm, "_tmo"}, 32'(bus_if.tmo_err), 32'd0);
  endtask
  initial begin
    int lowc, hold, tmo_at, tmo_cnt, g2cnt;
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    step();
    step();
    rst = 1'b0;
    chk_reset_outputs("reset");
    // single request tenure
    dmr_n = 4'b1110;
    step();
    cmp("single_dmr_low", 32'(bus_if.pin_dmr_n), 32'd0);
    step();
    step();
    dmgo_n = 1'b0;
    step();
    cmp("single_grant", 32'(bus_if.dev_dmg_n), 32'hE);
    dmgo_n = 1'b1;
    step();
    step();
    sack_n = 4'b1110;
    lowc = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      lowc += int'(!bus_if.pin_sack_n);
    end
    sack_n = '1;
    step();
    cmp("single_sack_len", 32'(lowc), 32'd10);
    cmp("single_sack_end", 32'(bus_if.pin_sack_n), 32'd1);
    dmr_n = 4'b1100;
    step();
    dmgo_n = 1'b0;
    step();
    cmp("single_rr_next", 32'(bus_if.dev_dmg_n), 32'hD);
    dmgo_n = 1'b1;
    dmr_n = '1;
    step();
    step();
    // fairness with all devices requesting
    rst = 1'b1;
    step();
    rst = 1'b0;
    dmr_n = '0;
    hold = 0;
    for (int c = 0; c < 200 && order.size() < 5; c++) begin
      dmgo_n = bus_if.pin_dmr_n;
      sack_n = '1;
      for (int d = 0; d < NDEV; d++) begin
        if (!bit_at(bus_if.dev_dmg_n, d)) begin
          order.push_back(d);
          sack_n &= ~(NDEV'(1) << d);
          hold = 0;
        end
        if (bit_at(bus_if.bus_own, d) && hold < 3) begin
          sack_n &= ~(NDEV'(1) << d);
          hold++;
        end
      end
      step();
    end
    cmp("fair_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5 && i < order.size(); i++) cmp("fair_order", 32'(order[i]), 32'(exp_order[i]));
    sack_n = '1;
    dmr_n = '1;
    dmgo_n = 1'b1;
    step();
    step();
    // timeout on device 2, device 3 pending
    dmr_n = 4'b0011;
    step();
    dmgo_n = 1'b0;
    step();
    g2cnt = int'(!bus_if.dev_dmg_n[2]);
    tmo_at = -1;
    tmo_cnt = 0;
    for (int k = 1; k <= TMO + 2; k++) begin
      step();
      if (bus_if.tmo_err) begin
        tmo_at = k;
        tmo_cnt++;
      end
      g2cnt += int'(!bus_if.dev_dmg_n[2]);
    end
    cmp("tmo_at", 32'(tmo_at), 32'(TMO));
    cmp("tmo_cnt", 32'(tmo_cnt), 32'd1);
    cmp("tmo_grant_len", 32'(g2cnt), 32'(TMO));
    cmp("tmo_next_winner", 32'(bus_if.dev_dmg_n), 32'h7);
    dmr_n = '1;
    dmgo_n = 1'b1;
    step();
    step();
    // withdrawal in REQ keeps RR
    dmr_n = 4'b1101;
    step();
    dmr_n = '1;
    step();
    cmp("wd_dmr_n", 32'(bus_if.pin_dmr_n), 32'd1);
    cmp("wd_no_grant", 32'(bus_if.dev_dmg_n), 32'hF);
    dmr_n = 4'b1010;
    step();
    dmgo_n = 1'b0;
    step();
    cmp("wd_rr_kept", 32'(bus_if.dev_dmg_n), 32'hE);
    // reset while device 0 owns the bus
    sack_n = 4'b1110;
    dmgo_n = 1'b1;
    step();
    cmp("own_before_rst", 32'(bus_if.bus_own), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs("rst_own");
    sack_n = '1;
    dmr_n = 4'b1100;
    step();
    dmgo_n = 1'b0;
    step();
    cmp("rst_rr_zero", 32'(bus_if.dev_dmg_n), 32'hE);
    // stray SACK from device 3 while device 1 is granted
    dmr_n = '1;
    dmgo_n = 1'b1;
    step();
    dmr_n = 4'b1101;
    step();
    dmgo_n = 1'b0;
    step();
    sack_n = 4'b0111;
    dmgo_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      cmp("stray_grant", 32'(bus_if.dev_dmg_n), 32'hD);
      cmp("stray_sack_n", 32'(bus_if.pin_sack_n), 32'd1);
    end
    sack_n = 4'b1101;
    step();
    sack_n = '1;
    dmr_n = '1;
    step();
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int d = 0; d < NDEV; d++) if ($urandom_range(0, 7) == 0) dmr_n ^= NDEV'(1) << d;
      dmgo_n = ($urandom_range(0, 3) == 0);
      sack_n = '1;
      for (int d = 0; d < NDEV; d++)
        if ((!bit_at(bus_if.dev_dmg_n, d) && $urandom_range(0, 5) == 0) ||
            (bit_at(bus_if.bus_own, d) && $urandom_range(0, 7) != 0) ||
            $urandom_range(0, 15) == 0)
          sack_n &= ~(NDEV'(1) << d);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
